dm_wait_responder: RTL
======================

DM_WAIT_RESPONDER -- requirements
Module: dm_wait_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning stall cycles inserted per access (range 0..15).
REQ-002 Parameter DEPTH, default 1024, meaning number of 32-bit words stored (power of two, at most 32768).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 DM_CEB  input  1  chip enable, active-low; 0 = request present.
REQ-006 dm_web  input  1  write enable, active-low; 0 = write, 1 = read.
REQ-007 dm_bweb  input  32  bit write mask, active-low; bit i = 0 writes data bit i.
REQ-008 dm_addr  input  15  word address.
REQ-009 dm_data_in  input  32  write data.
REQ-010 dm_data_out  output  32  registered read data.
REQ-011 DM_STOP  output  1  stall to the requester; 1 = requester must hold its request and freeze.

Function
REQ-012 The block SHALL implement the FSM states IDLE and WAIT, plus a 4-bit down-counter cnt.
REQ-013 The word index SHALL be dm_addr mod DEPTH, using the low log2(DEPTH) bits; upper address bits wrap silently.
REQ-014 In IDLE, DM_CEB=1 SHALL leave the state and cnt unchanged, hold DM_STOP=0, and hold dm_data_out.
REQ-015 If LATENCY=0, IDLE with DM_CEB=0 SHALL perform the access at that edge from live inputs; DM_STOP stays 0 and the state stays IDLE.
REQ-016 If LATENCY>0, IDLE with DM_CEB=0 SHALL drive DM_STOP=1 combinationally in that cycle.
REQ-017 Under REQ-016, the block SHALL latch addr, web, bweb and data_in at that edge, load cnt=LATENCY-1, and go to WAIT.
REQ-018 In WAIT with cnt!=0, the block SHALL drive DM_STOP=1, decrement cnt, and ignore all inputs.
REQ-019 In WAIT with cnt==0, the block SHALL drive DM_STOP=0, perform the latched access at that edge, and return to IDLE.
REQ-020 DM_STOP SHALL therefore be high for exactly LATENCY consecutive cycles per access.
REQ-021 Read access: dm_data_out SHALL be loaded with mem[index] at the access edge and become valid in the following cycle.
REQ-022 Write access: for each bit i with bweb[i]=0, mem[index][i] SHALL take data_in[i]; all other bits are unchanged.
REQ-023 A write access SHALL leave dm_data_out unchanged.
REQ-024 Read-after-write to the same index in consecutive accesses SHALL return the newly written data.
REQ-025 A new request SHALL be accepted in the first IDLE cycle after an access (back-to-back), with no extra dead cycle.
REQ-026 A write with bweb=all-ones SHALL complete the full handshake but modify no memory.

Reset
REQ-027 While rst=0 at an edge, state SHALL become IDLE, cnt=0 and dm_data_out=32'h0.
REQ-028 DM_STOP SHALL be 0 in the cycle after reset is applied.
REQ-029 Reset asserted during WAIT SHALL discard the pending access; the memory is not written and dm_data_out is not updated.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Inputs SHALL be ignored while rst=0.

Verification
REQ-032 With LATENCY=2: write addr 5, data 32'hDEADBEEF, bweb=0 -> DM_STOP high for 2 cycles, then low; then read addr 5 -> dm_data_out=32'hDEADBEEF the cycle after DM_STOP falls.
REQ-033 Byte mask: write 32'hFFFFFFFF to addr 7, then write 32'h00000000 to addr 7 with bweb=32'hFFFF00FF, then read addr 7 -> 32'hFFFF00FF.
REQ-034 Wrap: DEPTH=1024, write 32'h12345678 to addr 15'h0403, then read addr 15'h0003 -> 32'h12345678.
REQ-035 Back-to-back: keep DM_CEB=0 for 3 reads at addrs 1, 2, 3 -> DM_STOP pattern 1,1,0 repeated three times with no gaps; results valid one cycle after each DM_STOP fall.
REQ-036 Reset mid-WAIT: start a write of 32'hA5A5A5A5 to addr 9 (old value 32'h0), pulse rst=0 on the first WAIT cycle, then read addr 9 -> 32'h0; dm_data_out=0 immediately after reset.
REQ-037 With LATENCY=0: a read SHALL never raise DM_STOP, and data SHALL be valid the next cycle.

Source files
------------

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: single-port data memory that stalls each access for LATENCY cycles via DM_STOP.
module dm_wait_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_CEB,
    input  logic        dm_web,
    input  logic [31:0] dm_bweb,
    input  logic [14:0] dm_addr,
    input  logic [31:0] dm_data_in,
    output logic [31:0] dm_data_out,
    output logic        DM_STOP
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] AMASK = 15'(DEPTH - 1);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic LAT0 = (LATENCY == 0);

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          web_q;
    logic [31:0]   bweb_q, data_q, dout_q;
    logic [14:0]   addr_q;
    logic [31:0]   mem [DEPTH];
    logic          req, in_wait, acc, acc_web;
    logic [31:0]   acc_bweb, acc_data;
    logic [14:0]   acc_addr;
    logic [AW-1:0] idx;

    assign req      = rst && !DM_CEB && state_q == S_IDLE;
    assign in_wait  = state_q == S_WAIT;
    // With zero latency the access happens straight from the live request.
    assign acc      = rst && (LAT0 ? req : in_wait && cnt_q == 4'd0);
    assign DM_STOP  = rst && !LAT0 && (req || (in_wait && cnt_q != 4'd0));
    assign acc_web  = LAT0 ? dm_web : web_q;
    assign acc_bweb = LAT0 ? dm_bweb : bweb_q;
    assign acc_data = LAT0 ? dm_data_in : data_q;
    assign acc_addr = LAT0 ? dm_addr : addr_q;
    assign idx      = AW'(acc_addr & AMASK);
    assign dm_data_out = dout_q;

    always_comb begin
        state_d = (!LAT0 && req) ? S_WAIT : (acc ? S_IDLE : state_q);
        cnt_d   = (!LAT0 && req) ? LAT_M1 : ((in_wait && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc && acc_web) dout_q <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (req) begin
            web_q  <= dm_web;
            bweb_q <= dm_bweb;
            addr_q <= dm_addr;
            data_q <= dm_data_in;
        end
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (acc && !acc_web) mem[idx] <= (mem[idx] & acc_bweb) | (acc_data & ~acc_bweb);
    end
endmodule
